imm_decode_stage: RTL and testbench

- Pipeline register stage directly upstream of the immediate extension units in the simple 16-bit core.
- Accepts fetched 16-bit instruction words and extracts the 8-bit immediate field.
- Classifies the extension each instruction needs: sign-extend 8 bits, zero-extend shift amount, or none.
- Presents a registered immediate plus extension control to the extension/ALU-operand stage over a valid/ready handshake, with a 2-entry skid buffer so in_ready is a pure register output.

---
 rtl/imm_decode_stage.sv | 154 +++++++++++++++
 tb/tb_imm_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Pipeline register stage in front of the immediate extension units of the
//   16-bit core. Each accepted instruction word is decoded into an 8-bit
//   immediate field plus extension control (sign vs. zero, immediate present)
//   and held for the extension/ALU-operand stage behind a valid/ready
//   handshake. A two-entry skid buffer (main M, skid S) lets in_ready come
//   straight from a flop.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous discard of both buffered entries (taken branch)
//   in_valid     instruction word valid
//   in_ready     stage can accept a word (registered, equals !S_full)
//   in_inst      instruction: [15:14] op1, [13:11] ra/op2, [10:8] rb,
//                [7:0] d, [7:4] op3
//   out_valid    decoded entry available in M
//   out_ready    downstream accepts the entry
//   out_imm      immediate field for the extension unit
//   out_ext_sign 1 = sign-extend out_imm, 0 = zero-extend
//   out_has_imm  instruction uses an immediate operand
//   out_ra       ra/op2 field
//   out_rb       rb field
//   out_op1      op1 field
module imm_decode_stage #(
  parameter int IW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_inst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_imm,
  output logic          out_ext_sign,
  output logic          out_has_imm,
  output logic [2:0]    out_ra,
  output logic [2:0]    out_rb,
  output logic [1:0]    out_op1
);

  // Entry layout: {op1, ra, rb, has_imm, ext_sign, imm}
  localparam int EW = DW + 10;

  logic [1:0]    op1;
  logic [2:0]    op2;
  logic [3:0]    op3;
  logic [DW-1:0] dec_imm;
  logic          dec_sign;
  logic          dec_has;
  logic [EW-1:0] dec_entry;

  logic [EW-1:0] m_data;
  logic [EW-1:0] s_data;
  logic          m_valid;
  logic          s_valid;
  logic          in_ready_q;

  logic          accept;
  logic          xfer;

  assign op1 = in_inst[15:14];
  assign op2 = in_inst[13:11];
  assign op3 = in_inst[7:4];

  // Immediate classification. Loads/stores and LI/B/Bcc carry a signed 8-bit
  // offset; the shift group (op3 = 10xx) carries a 4-bit unsigned amount.
  always_comb begin
    dec_imm  = '0;
    dec_sign = 1'b0;
    dec_has  = 1'b0;
    unique case (op1)
      2'b00, 2'b01: begin
        dec_has  = 1'b1;
        dec_sign = 1'b1;
        dec_imm  = in_inst[DW-1:0];
      end
      2'b10: begin
        if (op2 == 3'b000 || op2 == 3'b100 || op2 == 3'b111) begin
          dec_has  = 1'b1;
          dec_sign = 1'b1;
          dec_imm  = in_inst[DW-1:0];
        end
      end
      2'b11: begin
        if (op3[3:2] == 2'b10) begin
          dec_has = 1'b1;
          dec_imm = {{(DW-4){1'b0}}, in_inst[3:0]};
        end
      end
      default: begin
      end
    endcase
  end

  assign dec_entry = {op1, in_inst[13:11], in_inst[10:8], dec_has, dec_sign, dec_imm};

  // in_ready is the registered !S_full, so no word can land while S is full.
  assign accept = in_valid && in_ready_q;
  assign xfer   = m_valid && out_ready;

  // Skid buffer. M is always the older entry. Whenever M frees up (empty or
  // transferring) it refills from S first, otherwise straight from the input,
  // which gives single-cycle latency and no bubble when streaming. A word
  // arriving while M is stalled parks in S and drops in_ready next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data     <= '0;
      s_data     <= '0;
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b0;
    end else if (flush) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (!m_valid || xfer) begin
        if (s_valid) begin
          m_data     <= s_data;
          m_valid    <= 1'b1;
          s_valid    <= 1'b0;
          in_ready_q <= 1'b1;
        end else if (accept) begin
          m_data     <= dec_entry;
          m_valid    <= 1'b1;
          in_ready_q <= 1'b1;
        end else begin
          m_valid    <= 1'b0;
          in_ready_q <= 1'b1;
        end
      end else if (accept) begin
        s_data     <= dec_entry;
        s_valid    <= 1'b1;
        in_ready_q <= 1'b0;
      end else begin
        in_ready_q <= !s_valid;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = m_valid;
  assign out_imm      = m_data[DW-1:0];
  assign out_ext_sign = m_data[DW];
  assign out_has_imm  = m_data[DW+1];
  assign out_rb       = m_data[DW+4:DW+2];
  assign out_ra       = m_data[DW+7:DW+5];
  assign out_op1      = m_data[DW+9:DW+8];

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
//   Directed and randomized stimulus for imm_decode_stage. The reference
//   model is a FIFO of decoded entries with capacity two: the front is what
//   the outputs must show, and in_ready must equal "fewer than two held".
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_imm;
  logic        out_ext_sign;
  logic        out_has_imm;
  logic [2:0]  out_ra;
  logic [2:0]  out_rb;
  logic [1:0]  out_op1;

  typedef struct {
    logic [7:0] imm;
    logic       sign;
    logic       has;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [1:0] op1;
  } ent_t;

  ent_t q[$];
  logic expReady;
  int   tests;
  int   fails;

  imm_decode_stage #(.IW(16), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_imm      (out_imm),
    .out_ext_sign (out_ext_sign),
    .out_has_imm  (out_has_imm),
    .out_ra       (out_ra),
    .out_rb       (out_rb),
    .out_op1      (out_op1)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode straight from the instruction-set rules
  function automatic ent_t refDecode(input logic [15:0] inst);
    ent_t e;
    int   o1;
    int   o2;
    int   o3;
    o1 = int'(inst[15:14]);
    o2 = int'(inst[13:11]);
    o3 = int'(inst[7:4]);
    e.imm  = 8'h00;
    e.sign = 1'b0;
    e.has  = 1'b0;
    e.ra   = inst[13:11];
    e.rb   = inst[10:8];
    e.op1  = inst[15:14];
    if (o1 < 2) begin
      e.has = 1'b1; e.sign = 1'b1; e.imm = inst[7:0];
    end else if (o1 == 2 && (o2 == 0 || o2 == 4 || o2 == 7)) begin
      e.has = 1'b1; e.sign = 1'b1; e.imm = inst[7:0];
    end else if (o1 == 3 && o3 >= 8 && o3 <= 11) begin
      e.has = 1'b1; e.imm = 8'(int'(inst[7:0]) % 16);
    end
    return e;
  endfunction

  // Single comparison with failure accounting
  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model front / occupancy
  task automatic checkOutput();
    checkOne("in_ready", 32'(in_ready), 32'(expReady));
    checkOne("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      checkOne("out_imm", 32'(out_imm), 32'(q[0].imm));
      checkOne("out_ext_sign", 32'(out_ext_sign), 32'(q[0].sign));
      checkOne("out_has_imm", 32'(out_has_imm), 32'(q[0].has));
      checkOne("out_ra", 32'(out_ra), 32'(q[0].ra));
      checkOne("out_rb", 32'(out_rb), 32'(q[0].rb));
      checkOne("out_op1", 32'(out_op1), 32'(q[0].op1));
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check
  task automatic applyStimulus(input logic v, input logic [15:0] inst,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      expReady = 1'b1;
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && expReady) q.push_back(refDecode(inst));
      expReady = (q.size() < 2);
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    expReady  = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 16'h8085;
    out_ready = 1'b1;

    // Reset held across edges with a valid word presented
    repeat (3) @(negedge clk);
    checkOne("rst_in_ready", 32'(in_ready), 32'd0);
    checkOne("rst_out_valid", 32'(out_valid), 32'd0);
    checkOne("rst_out_imm", 32'(out_imm), 32'd0);
    checkOne("rst_fields", 32'({out_ext_sign, out_has_imm, out_ra, out_rb, out_op1}), 32'd0);
    rst_n = 1'b1;

    // First edge after release: word ignored, in_ready rises
    applyStimulus(1'b1, 16'h8085, 1'b1, 1'b0);
    checkOne("ready_after_release", 32'(in_ready), 32'd1);
    checkOne("no_accept_in_reset", 32'(out_valid), 32'd0);

    // LI with negative immediate
    applyStimulus(1'b1, 16'b10_000_001_1000_0000, 1'b1, 1'b0);
    checkOne("li_imm", 32'(out_imm), 32'h80);
    checkOne("li_sign", 32'(out_ext_sign), 32'd1);
    checkOne("li_has", 32'(out_has_imm), 32'd1);
    checkOne("li_rb", 32'(out_rb), 32'd1);

    // Shift amount, zero-extended
    applyStimulus(1'b1, 16'b11_000_010_1001_0101, 1'b1, 1'b0);
    checkOne("sh_imm", 32'(out_imm), 32'h05);
    checkOne("sh_sign", 32'(out_ext_sign), 32'd0);
    checkOne("sh_has", 32'(out_has_imm), 32'd1);

    // ADD: no immediate
    applyStimulus(1'b1, 16'b11_000_010_0000_0101, 1'b1, 1'b0);
    checkOne("add_has", 32'(out_has_imm), 32'd0);
    checkOne("add_imm", 32'(out_imm), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: two loads stall, then drain in order
    applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0);
    checkOne("bp_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'h0070, 1'b0, 1'b0);
    checkOne("bp_hold_imm", 32'(out_imm), 32'h30);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOne("bp_second", 32'(out_imm), 32'h50);
    checkOne("bp_ready_back", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOne("bp_drained", 32'(out_valid), 32'd0);

    // Streaming: eight back-to-back words
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'h4010 + 16'(i), 1'b1, 1'b0);
      checkOne("stream_ready", 32'(in_ready), 32'd1);
      checkOne("stream_imm", 32'(out_imm), 32'h10 + 32'(i));
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush with both entries full and a word presented
    applyStimulus(1'b1, 16'h00A1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00A2, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00A3, 1'b0, 1'b1);
    checkOne("flush_valid", 32'(out_valid), 32'd0);
    checkOne("flush_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'h00B4, 1'b1, 1'b0);
    checkOne("post_flush_imm", 32'(out_imm), 32'hB4);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        expReady = 1'b0;
        checkOne("midrst_ready", 32'(in_ready), 32'd0);
        checkOne("midrst_valid", 32'(out_valid), 32'd0);
        checkOne("midrst_imm", 32'(out_imm), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
